// File: rtl/hazard_pkg.sv
// Shared definitions for the issue-stage hazard scoreboard: opcodes,
// forwarding-select encoding and the scoreboard entry layout.
package hazard_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  localparam int FWD_RF = 0;

  // rd is stored zero-extended to a fixed width so the struct can live here
  localparam int RD_W_MAX = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rd;
    logic                is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority finder for one source operand over the scoreboard.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic                  issue_valid,
  input  logic                  src_used,
  input  logic [REG_AW-1:0]     src,
  output logic [SEL_W-1:0]      sel,
  output logic                  load_block
);

  // Scan oldest to youngest so the lowest matching index is the last writer
  always_comb begin
    sel        = '0;
    load_block = 1'b0;
    if (issue_valid && src_used && (src != '0)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (entries[k].valid && (entries[k].rd == RD_W_MAX'(src))) begin
          if (entries[k].is_load && (k < LOAD_LAT - 1)) begin
            sel        = '0;
            load_block = 1'b1;
          end else begin
            sel        = SEL_W'(k + 1);
            load_block = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Age-ordered in-flight write tracker: per-operand forwarding select,
// load-use stall, redirect squash and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int DEPTH       = 3,
  parameter int LOAD_LAT    = 2,
  parameter int KILL_STAGES = 1,
  parameter int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic              issue_rs1_used,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_rs2_used,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_rd_we,
  input  logic              issue_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [DEPTH-1:0]  entry_valid,
  output logic [31:0]       stall_cycles
);

  sb_entry_t [DEPTH-1:0] sb_q;
  sb_entry_t [DEPTH-1:0] sb_d;
  logic [SEL_W-1:0]      sel_a;
  logic [SEL_W-1:0]      sel_b;
  logic                  blk_a;
  logic                  blk_b;
  logic [31:0]           cnt_q;

  hazard_match #(
    .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) u_match_a (
    .entries(sb_q), .issue_valid(issue_valid), .src_used(issue_rs1_used),
    .src(issue_rs1), .sel(sel_a), .load_block(blk_a)
  );

  hazard_match #(
    .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) u_match_b (
    .entries(sb_q), .issue_valid(issue_valid), .src_used(issue_rs2_used),
    .src(issue_rs2), .sel(sel_b), .load_block(blk_b)
  );

  // Redirect overrides both the stall and any forward for the dying instruction
  assign stall     = (blk_a | blk_b) & ~flush;
  assign fwd_sel_a = (stall | flush) ? SEL_W'(FWD_RF) : sel_a;
  assign fwd_sel_b = (stall | flush) ? SEL_W'(FWD_RF) : sel_b;

  // Backend never stalls: shift every cycle, bubble in on stall/flush
  always_comb begin
    sb_d = '0;
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
      if (flush && (k <= KILL_STAGES)) sb_d[k].valid = 1'b0;
    end
    if (issue_valid && !stall && !flush && issue_rd_we && (issue_rd != '0)) begin
      sb_d[0].valid   = 1'b1;
      sb_d[0].rd      = RD_W_MAX'(issue_rd);
      sb_d[0].is_load = issue_is_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt_q <= '0;
    else if (stall && (cnt_q != '1)) cnt_q <= cnt_q + 32'd1;
  end

  assign stall_cycles = cnt_q;

  always_comb begin
    entry_valid = '0;
    for (int k = 0; k < DEPTH; k++) entry_valid[k] = sb_q[k].valid;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a behavioural model predicts each
// cycle's outputs, plus directed checks of the key hazard scenarios.
module tb_hazard_scoreboard;

  localparam int DEPTH       = 3;
  localparam int LOAD_LAT    = 2;
  localparam int KILL_STAGES = 1;
  localparam int SEL_W       = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [4:0]       issue_rs1;
  logic             issue_rs1_used;
  logic [4:0]       issue_rs2;
  logic             issue_rs2_used;
  logic [4:0]       issue_rd;
  logic             issue_rd_we;
  logic             issue_is_load;
  logic             flush;
  logic             stall;
  logic [SEL_W-1:0] fwd_sel_a;
  logic [SEL_W-1:0] fwd_sel_b;
  logic [DEPTH-1:0] entry_valid;
  logic [31:0]      stall_cycles;

  hazard_scoreboard #(
    .REG_AW(5), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .KILL_STAGES(KILL_STAGES), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load),
    .flush(flush), .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .entry_valid(entry_valid), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             stall;
    logic [SEL_W-1:0] a;
    logic [SEL_W-1:0] b;
    logic [DEPTH-1:0] ev;
    logic [31:0]      cnt;
  } exp_t;

  exp_t expq[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic       m_v  [DEPTH];
  logic [4:0] m_rd [DEPTH];
  logic       m_ld [DEPTH];
  logic [31:0] m_cnt;

  logic             obs_stall;
  logic [SEL_W-1:0] obs_a;
  logic [SEL_W-1:0] obs_b;
  logic [DEPTH-1:0] obs_ev;
  logic [31:0]      obs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = 1'b0; m_rd[k] = '0; m_ld[k] = 1'b0;
    end
    m_cnt = '0;
  endfunction

  function automatic void src_eval(input logic [4:0] r, input logic u,
                                   output logic [SEL_W-1:0] s, output logic blk);
    s = '0; blk = 1'b0;
    if (issue_valid && u && (r != 5'd0)) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (m_v[k] && (m_rd[k] == r)) begin
          if (m_ld[k] && (k < LOAD_LAT - 1)) blk = 1'b1;
          else s = SEL_W'(k + 1);
          break;
        end
      end
    end
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    logic [SEL_W-1:0] sa, sb;
    logic ba, bb;
    src_eval(issue_rs1, issue_rs1_used, sa, ba);
    src_eval(issue_rs2, issue_rs2_used, sb, bb);
    e.stall = (ba | bb) & ~flush;
    e.a     = (e.stall | flush) ? '0 : sa;
    e.b     = (e.stall | flush) ? '0 : sb;
    for (int k = 0; k < DEPTH; k++) e.ev[k] = m_v[k];
    e.cnt   = m_cnt;
    return e;
  endfunction

  function automatic void model_step(input logic stl);
    if (stl && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      m_v[k]  = m_v[k-1];
      m_rd[k] = m_rd[k-1];
      m_ld[k] = m_ld[k-1];
      if (flush && (k <= KILL_STAGES)) m_v[k] = 1'b0;
    end
    m_v[0]  = issue_valid && !stl && !flush && issue_rd_we && (issue_rd != 5'd0);
    m_rd[0] = issue_rd;
    m_ld[0] = issue_is_load;
  endfunction

  task automatic cyc(input logic v, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                     input logic we, input logic ld, input logic fl);
    exp_t e, g;
    @(negedge clk);
    issue_valid = v; issue_rs1 = r1; issue_rs1_used = u1;
    issue_rs2 = r2; issue_rs2_used = u2; issue_rd = rd;
    issue_rd_we = we; issue_is_load = ld; flush = fl;
    e = model_eval();
    expq.push_back(e);
    #2;
    g = expq.pop_front();
    obs_stall = stall; obs_a = fwd_sel_a; obs_b = fwd_sel_b;
    obs_ev = entry_valid; obs_cnt = stall_cycles;
    chk("sb_stall", 32'(obs_stall), 32'(g.stall));
    chk("sb_fwd_a", 32'(obs_a), 32'(g.a));
    chk("sb_fwd_b", 32'(obs_b), 32'(g.b));
    chk("sb_entry_valid", 32'(obs_ev), 32'(g.ev));
    chk("sb_stall_cycles", obs_cnt, g.cnt);
    @(posedge clk);
    model_step(e.stall);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs1_used = 1'b0;
    issue_rs2 = '0; issue_rs2_used = 1'b0; issue_rd = '0;
    issue_rd_we = 1'b0; issue_is_load = 1'b0; flush = 1'b0;
    model_reset();
    #3;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fwd_a", 32'(fwd_sel_a), 32'd0);
    chk("rst_fwd_b", 32'(fwd_sel_b), 32'd0);
    chk("rst_entry_valid", 32'(entry_valid), 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // addi x5 ; add x6,x5,x5 ; idle ; read x5 at entry 2 ; read x5 after retire
    cyc(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0);
    cyc(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);
    chk("alu_fwd_stall", 32'(obs_stall), 32'd0);
    chk("alu_fwd_a", 32'(obs_a), 32'd1);
    chk("alu_fwd_b", 32'(obs_b), 32'd1);
    idle();
    cyc(1, 5'd0, 0, 5'd5, 1, 5'd0, 0, 0, 0);
    chk("oldest_fwd_b", 32'(obs_b), 32'd3);
    cyc(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    chk("retired_fwd_a", 32'(obs_a), 32'd0);

    // lw x7 ; add x8,x7,x0 stalls once then forwards from entry 1
    cyc(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0);
    cyc(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0);
    chk("loaduse_stall", 32'(obs_stall), 32'd1);
    chk("loaduse_fwd_a_held", 32'(obs_a), 32'd0);
    cyc(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0);
    chk("loaduse_release", 32'(obs_stall), 32'd0);
    chk("loaduse_fwd_a", 32'(obs_a), 32'd2);
    chk("loaduse_count", obs_cnt, 32'd1);

    // two writers of x3: youngest wins
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0);
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0);
    cyc(1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    chk("youngest_fwd_a", 32'(obs_a), 32'd1);

    // lw x9 ; consumer with flush -> no stall, no forward, entry killed
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0);
    cyc(1, 5'd9, 1, 5'd9, 1, 5'd10, 1, 0, 1);
    chk("flush_stall", 32'(obs_stall), 32'd0);
    chk("flush_fwd_a", 32'(obs_a), 32'd0);
    chk("flush_fwd_b", 32'(obs_b), 32'd0);
    idle();
    chk("flush_killed_e1", 32'(obs_ev[1]), 32'd0);
    chk("flush_no_e0", 32'(obs_ev[0]), 32'd0);

    // x0 is never a hazard
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
    cyc(1, 5'd0, 1, 5'd0, 1, 5'd4, 1, 0, 0);
    chk("x0_stall", 32'(obs_stall), 32'd0);
    chk("x0_fwd_a", 32'(obs_a), 32'd0);

    // reset asserted in the middle of a load-use stall
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 1, 0);
    @(negedge clk);
    issue_valid = 1'b1; issue_rs1 = 5'd11; issue_rs1_used = 1'b1;
    issue_rs2 = 5'd0; issue_rs2_used = 1'b0; issue_rd = 5'd12;
    issue_rd_we = 1'b1; issue_is_load = 1'b0; flush = 1'b0;
    #1;
    chk("midrst_pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_entry_valid", 32'(entry_valid), 32'd0);
    chk("midrst_count", stall_cycles, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    issue_valid = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      cyc(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end

    // counter saturation: preload near the top, then three load-use stalls
    #1;
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 1, 0);
    cyc(1, 5'd13, 1, 5'd0, 0, 5'd14, 1, 1, 0);
    cyc(1, 5'd13, 1, 5'd0, 0, 5'd14, 1, 1, 0);
    cyc(1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 1, 0);
    cyc(1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 1, 0);
    cyc(1, 5'd15, 1, 5'd0, 0, 5'd16, 1, 1, 0);
    cyc(1, 5'd15, 1, 5'd0, 0, 5'd16, 1, 1, 0);
    idle();
    chk("sat_count", obs_cnt, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
